// File: rtl/ysyx_040750_div_pkg.sv
// ysyx_040750_div_pkg
// Shared definitions for the RV64 divide controller and its radix-2 core:
// operand width, core latency, op encodings, FSM state encodings and a
// result-selection helper. It is used by both the controller and the testbench.
package ysyx_040750_div_pkg;

    localparam int XLEN         = 64;
    // Cycles from the core start pulse to the core done pulse.
    localparam int CORE_LATENCY = 66;

    // op[0] = 1 selects unsigned. op[1] = 1 selects the remainder.
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // Controller FSM state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Builds the architectural result. The quotient or remainder is chosen
    // from op[1]. The raw core value is replaced when the request is a
    // divide-by-zero or a signed-overflow case. For W ops, the low word is
    // sign-extended.
    function automatic logic [XLEN-1:0] select_result(
        input logic [1:0]      op,
        input logic            is_word,
        input logic [XLEN-1:0] dividend,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem,
        input logic            div_zero,
        input logic            overflow
    );
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        logic [XLEN-1:0] sel;
        q = quo;
        r = rem;
        if (div_zero) begin
            q = {XLEN{1'b1}};
            r = dividend;
        end else if (overflow) begin
            q = dividend;
            r = {XLEN{1'b0}};
        end
        sel = op[1] ? r : q;
        if (is_word) begin
            sel = {{32{sel[31]}}, sel[31:0]};
        end
        return sel;
    endfunction

endpackage

// File: rtl/ysyx_040750_radix2_div.sv
// ysyx_040750_radix2_div
// Iterative restoring radix-2 divider. The core works on magnitudes and
// applies the operand signs at the end. One start pulse produces a one-cycle
// done pulse CORE_LATENCY cycles later. The quotient and remainder are valid
// only while done is high.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            one-cycle request. It is ignored while busy.
//   is_signed        treat dividend and divisor as two's complement
//   dividend/divisor 64-bit operands
//   busy             a divide is in progress
//   done             one-cycle pulse. quotient and remainder are valid.
//   quotient, remainder  results
module ysyx_040750_radix2_div
    import ysyx_040750_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    // Cycle budget: 1 load + XLEN iterations + 1 sign fix-up = CORE_LATENCY.
    localparam logic [6:0] LAST_CNT = 7'(CORE_LATENCY - 2);

    logic [6:0]      cnt;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] div_r;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN:0]   rem_shift;
    logic            sub_ok;

    // The partial remainder stays below the divisor. Because of this, the
    // shifted value fits in XLEN+1 bits, and the new remainder fits in XLEN bits.
    assign rem_shift = {rem_r, quo_r[XLEN-1]};
    assign sub_ok    = (rem_shift >= {1'b0, div_r});

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= 7'd0;
            quo_r     <= '0;
            rem_r     <= '0;
            div_r     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy  <= 1'b1;
                cnt   <= 7'd0;
                rem_r <= '0;
                quo_r <= (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
                div_r <= (is_signed && divisor[XLEN-1]) ? -divisor : divisor;
                neg_q <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                neg_r <= is_signed && dividend[XLEN-1];
            end else if (busy) begin
                if (cnt == LAST_CNT) begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    quotient  <= neg_q ? -quo_r : quo_r;
                    remainder <= neg_r ? -rem_r : rem_r;
                end else begin
                    cnt <= cnt + 7'd1;
                    if (sub_ok) begin
                        rem_r <= rem_shift[XLEN-1:0] - div_r;
                        quo_r <= {quo_r[XLEN-2:0], 1'b1};
                    end else begin
                        rem_r <= rem_shift[XLEN-1:0];
                        quo_r <= {quo_r[XLEN-2:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_040750_div_ctrl.sv
// ysyx_040750_div_ctrl
// RV64M divide/remainder unit placed between EX and MEM/WB. The unit
// decodes the request, extends W operands, starts the radix-2 core,
// captures the selected result and presents it until the consumer takes it.
// Optional feature: define YSYX_040750_DIV_BYPASS_EN so that divide-by-zero
// and signed overflow are resolved without the core. The result is then
// valid the cycle after acceptance.
// Handshake: a transfer happens on a cycle where valid and ready are both high.
// On the input side, flush blocks the transfer. valid must not depend on
// ready. out_valid/result stay stable until out_ready or flush.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     request handshake (ready only in IDLE)
//   op, is_word           00 DIV, 01 DIVU, 10 REM, 11 REMU; RV64 W variant
//   src1, src2            dividend and divisor
//   flush                 kills the in-flight request
//   out_valid/out_ready   result handshake
//   result                64-bit architectural result
module ysyx_040750_div_ctrl
    import ysyx_040750_div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    logic [1:0]      state;
    logic [1:0]      op_q;
    logic            is_word_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic            div_zero_q;
    logic            overflow_q;
    logic            start_q;
    logic [XLEN-1:0] result_q;

    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            div_zero;
    logic            overflow;
    logic            accept;

    logic            core_start;
    logic            core_busy;
    logic            core_done;
    logic [XLEN-1:0] core_quo;
    logic [XLEN-1:0] core_rem;

    // Signed ops (op[0]=0) sign-extend the low word. Unsigned ops zero-extend it.
    assign a_ext = !is_word ? src1 :
                   op[0]    ? {32'd0, src1[31:0]} : {{32{src1[31]}}, src1[31:0]};
    assign b_ext = !is_word ? src2 :
                   op[0]    ? {32'd0, src2[31:0]} : {{32{src2[31]}}, src2[31:0]};

    assign div_zero = is_word ? (src2[31:0] == 32'd0) : (src2 == '0);
    // Overflow is checked at the operating width: most-negative / -1.
    assign overflow = !op[0] && (is_word
                    ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                    : (src1 == {1'b1, {(XLEN-1){1'b0}}} && src2 == {XLEN{1'b1}}));

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == ST_DONE);
    assign result    = result_q;

    assign core_start = start_q && !core_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= 2'b00;
            is_word_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            div_zero_q <= 1'b0;
            overflow_q <= 1'b0;
            start_q    <= 1'b0;
            result_q   <= '0;
        end else begin
            start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q       <= op;
                        is_word_q  <= is_word;
                        a_q        <= a_ext;
                        b_q        <= b_ext;
                        div_zero_q <= div_zero;
                        overflow_q <= overflow;
`ifdef YSYX_040750_DIV_BYPASS_EN
                        if (div_zero || overflow) begin
                            state    <= ST_DONE;
                            result_q <= select_result(op, is_word, a_ext, '0, '0,
                                                      div_zero, overflow);
                        end else begin
                            state   <= ST_BUSY;
                            start_q <= 1'b1;
                        end
`else
                        state   <= ST_BUSY;
                        start_q <= 1'b1;
`endif
                    end
                end
                ST_BUSY: begin
                    // The core outputs are valid only while done is high, so
                    // the result is captured on that cycle.
                    if (core_done) begin
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_DONE;
                            result_q <= select_result(op_q, is_word_q, a_q, core_quo,
                                                      core_rem, div_zero_q, overflow_q);
                        end
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (core_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ysyx_040750_radix2_div u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .is_signed (~op_q[0]),
        .dividend  (a_q),
        .divisor   (b_q),
        .busy      (core_busy),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

endmodule

// File: tb/tb_ysyx_040750_div_ctrl.sv
// tb_ysyx_040750_div_ctrl
// Directed bench for ysyx_040750_div_ctrl. A table of vectors is applied
// in a loop. After that come hand-written sequences for flush, back-pressure
// and reset corner cases. The expected latency of special cases follows
// YSYX_040750_DIV_BYPASS_EN.
module tb_ysyx_040750_div_ctrl;
    import ysyx_040750_div_pkg::*;

`ifdef YSYX_040750_DIV_BYPASS_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 67;
`endif
    localparam int CORE_LAT = 67;
    localparam int TIMEOUT  = 200;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        is_word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    ysyx_040750_div_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_word   (is_word),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard checks ----------------
    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Presents a request at a negedge. Acceptance happens at the next posedge.
    task automatic send(input logic [1:0] op_i, input logic w, input logic [63:0] a,
                        input logic [63:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        op       = op_i;
        is_word  = w;
        src1     = a;
        src2     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts posedges after acceptance until out_valid is seen at a negedge.
    task automatic wait_valid(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < TIMEOUT) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
    endtask

    // Runs one full request and checks its result, latency and release.
    // hold is the number of cycles out_ready stays low after out_valid.
    task automatic run_op(input string name, input logic [1:0] op_i, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input int exp_lat, input int hold);
        int          lat;
        bit          seen;
        logic [63:0] exp_v;
        @(negedge clk);
        check64({name, " in_ready_before"}, {63'd0, in_ready}, 64'd1);
        exp_q.push_back(exp);
        send(op_i, w, a, b);
        wait_valid(lat, seen);
        exp_v = exp_q.pop_front();
        check_int({name, " latency"}, lat, exp_lat);
        if (seen) begin
            check64({name, " result"}, result, exp_v);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check64({name, " held_result"}, result, exp_v);
                check64({name, " held_valid"}, {63'd0, out_valid}, 64'd1);
                check64({name, " held_in_ready"}, {63'd0, in_ready}, 64'd0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            check64({name, " valid_after_hs"}, {63'd0, out_valid}, 64'd0);
            check64({name, " in_ready_after_hs"}, {63'd0, in_ready}, 64'd1);
        end
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          special;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int  lat;
        int  ready_at;
        bit  seen;
        bit  bad_valid;

        vecs[0]  = '{"div_m7_2",     OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,  64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[1]  = '{"remw_ovf",     OP_REM,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
        vecs[2]  = '{"divw_ovf",     OP_DIV,  1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1};
        vecs[3]  = '{"divu_by0",     OP_DIVU, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[4]  = '{"remu_by0",     OP_REMU, 1'b0, 64'd100, 64'd0, 64'd100, 1'b1};
        vecs[5]  = '{"divu_9_3",     OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, 1'b0};
        vecs[6]  = '{"rem_7_m3",     OP_REM,  1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0};
        vecs[7]  = '{"div_ovf64",    OP_DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1};
        vecs[8]  = '{"rem_ovf64",    OP_REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
        vecs[9]  = '{"divuw",        OP_DIVU, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2, 64'h0000_0000_7FFF_FFF8, 1'b0};
        vecs[10] = '{"remw_m7_3",    OP_REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[11] = '{"divw_by0",     OP_DIV,  1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[12] = '{"remuw_by0",    OP_REMU, 1'b1, 64'h0000_0000_8000_0000, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b1};
        vecs[13] = '{"divu_big",     OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[14] = '{"div_m100_7",   OP_DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        op        = 2'b00;
        is_word   = 1'b0;
        src1      = '0;
        src2      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check64("reset in_ready", {63'd0, in_ready}, 64'd1);
        check64("reset out_valid", {63'd0, out_valid}, 64'd0);
        check64("reset result", result, 64'd0);

        // Table-driven vectors.
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b,
                   vecs[i].exp, vecs[i].special ? SPECIAL_LAT : CORE_LAT, 0);
        end

        // A request together with flush in IDLE is rejected.
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = OP_DIVU; is_word = 1'b0; src1 = 64'd8; src2 = 64'd2;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check64("idle_flush in_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) @(negedge clk);
        check64("idle_flush out_valid", {63'd0, out_valid}, 64'd0);

        // Flush in BUSY: there is no output, and in_ready stays low until the core done pulse + 1.
        send(OP_DIV, 1'b0, 64'd1000, 64'd10);
        bad_valid = 1'b0;
        ready_at  = -1;
        for (int k = 1; k < TIMEOUT && ready_at < 0; k++) begin
            if (k == 20) flush = 1'b1;
            @(posedge clk);
            #1;
            flush = 1'b0;
            @(negedge clk);
            if (out_valid) bad_valid = 1'b1;
            if (in_ready) ready_at = k;
        end
        check_int("busy_flush in_ready_at", ready_at, CORE_LAT);
        repeat (5) begin
            @(negedge clk);
            if (out_valid) bad_valid = 1'b1;
        end
        check64("busy_flush no_out_valid", {63'd0, bad_valid}, 64'd0);
        run_op("after_flush divu_9_3", OP_DIVU, 1'b0, 64'd9, 64'd3, 64'd3, CORE_LAT, 0);

        // Back-pressure: out_ready is held low for 10 cycles.
        run_op("rem_m9_4 hold", OP_REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF7, 64'd4,
               64'hFFFF_FFFF_FFFF_FFFF, CORE_LAT, 10);

        // Flush in DONE drops the result.
        send(OP_DIV, 1'b0, 64'd50, 64'd5);
        wait_valid(lat, seen);
        check_int("done_flush latency", lat, CORE_LAT);
        check64("done_flush result", result, 64'd10);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check64("done_flush out_valid", {63'd0, out_valid}, 64'd0);
        check64("done_flush in_ready", {63'd0, in_ready}, 64'd1);

        // out_ready has no effect while BUSY. Reset in mid-BUSY abandons the divide.
        send(OP_DIVU, 1'b0, 64'd77, 64'd7);
        out_ready = 1'b1;
        repeat (30) @(negedge clk);
        check64("busy out_ready in_ready", {63'd0, in_ready}, 64'd0);
        out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check64("mid_rst out_valid", {63'd0, out_valid}, 64'd0);
        check64("mid_rst in_ready", {63'd0, in_ready}, 64'd1);
        check64("mid_rst result", result, 64'd0);
        bad_valid = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) bad_valid = 1'b1;
        end
        check64("mid_rst no_late_valid", {63'd0, bad_valid}, 64'd0);
        run_op("after_rst divu_77_7", OP_DIVU, 1'b0, 64'd77, 64'd7, 64'd11, CORE_LAT, 0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_040750_div_ctrl.md
YSYX_040750_DIV_CTRL -- requirements
Module: ysyx_040750_div_ctrl

Interface
REQ-001 SHALL have ports, one per line, in order: name  direction  width  meaning:
  clk        input   1   single clock; all state updates on rising edge
  rst        input   1   reset, synchronous, active-high
  in_valid   input   1   EX-stage divide request valid
  in_ready   output  1   block can accept a request
  op         input   2   00 DIV, 01 DIVU, 10 REM, 11 REMU
  is_word    input   1   RV64 W-variant (32-bit operands/result)
  src1       input   64  dividend operand
  src2       input   64  divisor operand
  flush      input   1   pipeline kill; discard in-flight request
  out_valid  output  1   result valid toward MEM/WB
  out_ready  input   1   downstream accepts result
  result     output  64  final RV64 result

Function
REQ-002 SHALL implement FSM states IDLE, BUSY, DRAIN, DONE.
REQ-003 SHALL assert in_ready only in IDLE; accept on in_valid & in_ready & ~flush.
REQ-004 SHALL latch op, is_word, operands and special-case flags on acceptance.
REQ-005 SHALL, for is_word, sign-extend (DIV/REM) or zero-extend (DIVU/REMU) src1[31:0]/src2[31:0] to 64 bits before use.
REQ-006 SHALL issue a one-cycle start pulse to the divider core in the cycle after acceptance; never while the core is busy.
REQ-007 SHALL drive core is_signed = ~op[0].
REQ-008 SHALL capture quotient (op[1]=0) or remainder (op[1]=1) in the exact cycle the core's one-cycle done pulse is high; core outputs are undefined afterwards.
REQ-009 SHALL, for is_word, output {32{r[31]}, r[31:0]} of the selected result.
REQ-010 SHALL on divisor==0 produce quotient all-ones (W: 0xFFFFFFFF sign-extended) and remainder = extended dividend.
REQ-011 SHALL on signed overflow (dividend = most negative, divisor = -1, at operating width) produce quotient = dividend, remainder = 0.
REQ-012 SHALL hold out_valid and result stable in DONE until out_ready; return to IDLE on handshake.
REQ-013 SHALL, for the core path, assert out_valid exactly 67 cycles after the acceptance cycle.
REQ-014 SHALL on flush in BUSY enter DRAIN, suppress the result, and return to IDLE the cycle after the core done pulse.
REQ-015 SHALL on flush in DONE drop out_valid next cycle and return to IDLE.
REQ-016 SHALL ignore flush in IDLE and DRAIN (no state change beyond rejecting acceptance).
REQ-017 SHALL give out_ready no effect outside DONE.

Reset
REQ-018 SHALL on rst: state IDLE, out_valid 0, result 0, start pulse 0, in_ready 1 the following cycle.
REQ-019 SHALL reset the core with the same rst; reset mid-operation abandons the divide with no output.

Configuration
REQ-020 SHALL, with YSYX_040750_DIV_BYPASS_EN defined, resolve divide-by-zero and overflow without starting the core: out_valid in the cycle after acceptance.
REQ-021 SHALL, without YSYX_040750_DIV_BYPASS_EN, run special cases through the core and substitute REQ-010/011 values at capture; latency per REQ-013; results bit-identical in both builds.

Structure
REQ-022 SHALL place op encodings, state enum, and width constants (XLEN=64, core latency=66) in shared package ysyx_040750_div_pkg.
REQ-023 SHALL instantiate exactly one sub-module: the iterative radix-2 divider core ysyx_040750_radix2_div; all other logic inline.

Verification
REQ-024 DIV src1=-7, src2=2 -> result 0xFFFFFFFFFFFFFFFD, out_valid 67 cycles after accept.
REQ-025 REMW src1=0x00000000_80000000, src2=0xFFFFFFFF_FFFFFFFF -> result 0 (overflow); DIVW same -> 0xFFFFFFFF80000000.
REQ-026 DIVU src1=100, src2=0 -> 0xFFFFFFFFFFFFFFFF; REMU same -> 100; 1 cycle with BYPASS_EN, 67 without.
REQ-027 DIV 1000/10 accepted, flush 20 cycles later -> no out_valid; in_ready low until core done+1; next DIVU 9/3 -> 3.
REQ-028 REM -9/4 -> 0xFFFFFFFFFFFFFFFF with out_ready held low 10 cycles -> result stable, in_ready low throughout; rst asserted mid-BUSY -> out_valid 0, IDLE next cycle.
